// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the weight path of the systolic-array TPU:
//   - DEFAULT_WIDTH_HEIGHT : default systolic array dimension (rows = cols)
//   - MAX_MASK_W           : widest row the column-mask helper can describe
//   - wmf_state_e          : states of the weight memory -> FIFO mover
//   - col_byte_mask()      : byte-enable mask keeping columns 0..num_col
// ----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DEFAULT_WIDTH_HEIGHT = 16;
    localparam int MAX_MASK_W           = 64 * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAD  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } wmf_state_e;

    // Bytes 0..num_col are all ones, every higher byte is zero. Callers cast
    // the result down to their own row width.
    function automatic logic [MAX_MASK_W-1:0] col_byte_mask(input int unsigned num_col);
        logic [MAX_MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_MASK_W / 8; i++) begin
            if (i <= num_col) begin
                m[i*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/weight_row_buf.sv
// ----------------------------------------------------------------------------
// weight_row_buf
// Two-entry in-order buffer holding weight rows returned by memory until the
// weight FIFO accepts them.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (empties buffer)
//   flush           : synchronous empty, overrides wr_en/rd_en
//   wr_en, wr_data  : append a row (caller guarantees not full)
//   rd_en           : drop the head row (caller guarantees not empty)
//   rd_data         : current head row
//   count           : number of rows held (0..2)
// ----------------------------------------------------------------------------
module weight_row_buf #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = wr_data;
                    end else begin
                        tail_d = wr_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous pop and push: count is unchanged, the new
                    // row goes behind whatever remains after the pop.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = wr_data;
                    end else begin
                        head_d = wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Row storage needs no reset: count alone says which entries are valid.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign rd_data = head_q;
    assign count   = count_q;

endmodule

// File: rtl/weight_mem_fifo_control.sv
// ----------------------------------------------------------------------------
// weight_mem_fifo_control
// Moves one weight tile from weight memory into the weight FIFO feeding the
// systolic array. Unused rows are padded with zero rows pushed first, unused
// columns are masked to zero, so the FIFO always receives WIDTH_HEIGHT rows.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   weight_mem_fifo_en    : job request / hold level from the multiply master
//   num_row, num_col      : valid rows-1 / valid columns-1 of the tile
//   base_addr             : memory address of tile row 0
//   mem_rd_en, mem_addr   : memory read strobe and address
//   mem_rd_data           : read data, valid one cycle after mem_rd_en
//   fifo_wr_en/_data      : push to the weight FIFO (byte i = column i)
//   fifo_full             : FIFO cannot accept a push this cycle
//   weight_mem_fifo_done  : one-cycle pulse after the final push
// ----------------------------------------------------------------------------
module weight_mem_fifo_control
    import tpu_pkg::*;
#(
    parameter int WIDTH_HEIGHT = DEFAULT_WIDTH_HEIGHT,
    parameter int DATA_WIDTH   = WIDTH_HEIGHT * 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            weight_mem_fifo_en,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0] num_row,
    input  logic [$clog2(WIDTH_HEIGHT)-1:0] num_col,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0]           mem_rd_data,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data,
    input  logic                            fifo_full,
    output logic                            weight_mem_fifo_done
);

    localparam int CW = $clog2(WIDTH_HEIGHT);
    localparam int RW = CW + 1;   // holds row counts up to WIDTH_HEIGHT

    wmf_state_e            state_q, state_d;
    logic [CW-1:0]         num_col_q, num_col_d;
    logic [CW-1:0]         pad_cnt_q, pad_cnt_d;
    logic [RW-1:0]         rd_left_q, rd_left_d;
    logic [RW-1:0]         push_left_q, push_left_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_d;

    logic [CW-1:0]         pad_init;
    logic [DATA_WIDTH-1:0] col_mask;
    logic                  rd_issue;

    logic                  buf_flush;
    logic                  buf_wr;
    logic                  buf_pop;
    logic [DATA_WIDTH-1:0] buf_rd_data;
    logic [1:0]            buf_count;

    assign pad_init = CW'(WIDTH_HEIGHT - 1) - num_row;
    assign col_mask = DATA_WIDTH'(col_byte_mask(32'(num_col_q)));

    weight_row_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row_buf (
        .clk     (clk),
        .reset   (reset),
        .flush   (buf_flush),
        .wr_en   (buf_wr),
        .wr_data (mem_rd_data & col_mask),
        .rd_en   (buf_pop),
        .rd_data (buf_rd_data),
        .count   (buf_count)
    );

    always_comb begin
        state_d     = state_q;
        num_col_d   = num_col_q;
        pad_cnt_d   = pad_cnt_q;
        rd_left_d   = rd_left_q;
        push_left_d = push_left_q;
        rd_addr_d   = rd_addr_q;
        inflight_d  = 1'b0;

        mem_rd_en            = 1'b0;
        mem_addr             = '0;
        fifo_wr_en           = 1'b0;
        fifo_wr_data         = '0;
        weight_mem_fifo_done = 1'b0;
        buf_flush            = 1'b0;
        buf_wr               = 1'b0;
        buf_pop              = 1'b0;
        rd_issue             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (weight_mem_fifo_en) begin
                    num_col_d   = num_col;
                    pad_cnt_d   = pad_init;
                    // Reads descend so tile row 0 is pushed last.
                    rd_addr_d   = base_addr + ADDR_WIDTH'(num_row);
                    rd_left_d   = RW'(num_row) + RW'(1);
                    push_left_d = RW'(num_row) + RW'(1);
                    state_d     = (pad_init == '0) ? ST_LOAD : ST_PAD;
                end
            end

            ST_PAD: begin
                if (!weight_mem_fifo_en) begin
                    state_d   = ST_IDLE;
                    buf_flush = 1'b1;
                end else if (!fifo_full) begin
                    fifo_wr_en = 1'b1;
                    pad_cnt_d  = pad_cnt_q - CW'(1);
                    if (pad_cnt_q == CW'(1)) begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (!weight_mem_fifo_en) begin
                    // Abort: drop buffered rows; inflight_d stays 0 so the
                    // pending read return is ignored.
                    state_d   = ST_IDLE;
                    buf_flush = 1'b1;
                end else begin
                    buf_wr       = inflight_q;
                    buf_pop      = (buf_count != 2'd0) && !fifo_full;
                    fifo_wr_en   = buf_pop;
                    fifo_wr_data = buf_rd_data;

                    // Credit: rows buffered plus the one in flight, less this
                    // cycle's pop, must leave room for the new read's return.
                    rd_issue = (rd_left_q != '0) &&
                               (({1'b0, buf_count} + {2'b00, inflight_q}) <
                                (3'd2 + {2'b00, buf_pop}));
                    mem_rd_en  = rd_issue;
                    inflight_d = rd_issue;
                    if (rd_issue) begin
                        mem_addr  = rd_addr_q;
                        rd_addr_d = rd_addr_q - ADDR_WIDTH'(1);
                        rd_left_d = rd_left_q - RW'(1);
                    end

                    if (buf_pop) begin
                        push_left_d = push_left_q - RW'(1);
                        if (push_left_q == RW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                weight_mem_fifo_done = 1'b1;
                state_d              = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_col_q   <= '0;
            pad_cnt_q   <= '0;
            rd_left_q   <= '0;
            push_left_q <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_col_q   <= num_col_d;
            pad_cnt_q   <= pad_cnt_d;
            rd_left_q   <= rd_left_d;
            push_left_q <= push_left_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_weight_mem_fifo_control.sv
module tb_weight_mem_fifo_control;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [3:0]   num_row;
    logic [3:0]   num_col;
    logic [7:0]   base_addr;
    logic         mem_rd_en;
    logic [7:0]   mem_addr;
    logic [127:0] mem_rd_data;
    logic         fifo_wr_en;
    logic [127:0] fifo_wr_data;
    logic         fifo_full;
    logic         done;

    always #5 clk = ~clk;

    weight_mem_fifo_control #(
        .WIDTH_HEIGHT (16),
        .DATA_WIDTH   (128),
        .ADDR_WIDTH   (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .weight_mem_fifo_en   (en),
        .num_row              (num_row),
        .num_col              (num_col),
        .base_addr            (base_addr),
        .mem_rd_en            (mem_rd_en),
        .mem_addr             (mem_addr),
        .mem_rd_data          (mem_rd_data),
        .fifo_wr_en           (fifo_wr_en),
        .fifo_wr_data         (fifo_wr_data),
        .fifo_full            (fifo_full),
        .weight_mem_fifo_done (done)
    );

    int checks   = 0;
    int failures = 0;

    // Memory contents and the expected traffic of the current job.
    logic [127:0] mem [256];
    logic [7:0]   exp_addr_q [$];
    logic [127:0] exp_push_q [$];

    int ncyc = 0;
    int t0   = 0;
    bit job_active = 1'b0;
    int fmode = 0;
    bit abort_mode = 1'b0;
    int abort_cyc = 0;
    int n_pad_exp = 0;
    int n_rd, n_push, n_mpush, n_done;
    int first_rd, last_rd, first_push, last_push, done_cyc;
    bit rd_pend = 1'b0;
    logic [7:0] rd_addr_s;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder, FIFO backpressure and traffic monitor.
    initial begin
        int cur;
        int rel;
        fifo_full   = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) mem_rd_data = mem[rd_addr_s];
            else         mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
            rd_pend = 1'b0;
            cur = ncyc - t0;
            if (!job_active)     fifo_full = 1'b0;
            else if (fmode == 1) fifo_full = (cur >= 5 && cur <= 9);
            else if (fmode == 2) fifo_full = ($urandom_range(0, 9) < 3);
            else                 fifo_full = 1'b0;

            @(negedge clk);
            ncyc++;
            if (mem_rd_en) begin
                rd_pend   = 1'b1;
                rd_addr_s = mem_addr;
            end
            if (job_active) begin
                rel = ncyc - t0 - 1;
                if (abort_mode && rel > abort_cyc) begin
                    check("abort_rd_en", mem_rd_en, 0);
                    check("abort_wr_en", fifo_wr_en, 0);
                    check("abort_done", done, 0);
                end else begin
                    if (fifo_full) check("push_while_full", fifo_wr_en, 0);
                    if (mem_rd_en) begin
                        n_rd++;
                        if (first_rd < 0) first_rd = rel;
                        last_rd = rel;
                        check("rd_expected", exp_addr_q.size() > 0, 1);
                        if (exp_addr_q.size() > 0) check("rd_addr", mem_addr, exp_addr_q.pop_front());
                    end
                    if (fifo_wr_en) begin
                        n_push++;
                        if (n_push > n_pad_exp) n_mpush++;
                        if (first_push < 0) first_push = rel;
                        last_push = rel;
                        check("push_expected", exp_push_q.size() > 0, 1);
                        if (exp_push_q.size() > 0) check("push_data", fifo_wr_data, exp_push_q.pop_front());
                    end
                    if (!abort_mode) check("occupancy_le2", (n_rd - n_mpush) <= 2, 1);
                    if (done) begin
                        n_done++;
                        done_cyc = rel;
                    end
                end
            end
        end
    end

    // One job: build the expected traffic from the tile rules, then drive it.
    // ab > 0 drops the enable in that cycle; rs > 0 asserts reset in that cycle.
    task automatic run_job(input logic [3:0] nr, input logic [3:0] nc, input logic [7:0] base,
                           input int fm, input int ab, input int rs);
        logic [127:0] row;
        logic [7:0]   a;
        exp_addr_q.delete();
        exp_push_q.delete();
        n_pad_exp = 15 - int'(nr);
        for (int i = 0; i < n_pad_exp; i++) exp_push_q.push_back('0);
        for (int r = int'(nr); r >= 0; r--) begin
            a = base + 8'(r);
            exp_addr_q.push_back(a);
            row = '0;
            for (int b = 0; b <= int'(nc); b++) row[b*8 +: 8] = mem[a][b*8 +: 8];
            exp_push_q.push_back(row);
        end
        n_rd = 0; n_push = 0; n_mpush = 0; n_done = 0;
        first_rd = -1; last_rd = -1; first_push = -1; last_push = -1; done_cyc = -1;

        @(posedge clk);
        #3;
        num_row    = nr;
        num_col    = nc;
        base_addr  = base;
        en         = 1'b1;
        fmode      = fm;
        abort_mode = (ab > 0);
        abort_cyc  = ab;
        t0         = ncyc;
        job_active = 1'b1;

        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #3;
            if (rs > 0 && (ncyc - t0) == rs) begin
                job_active = 1'b0;
                reset = 1'b1;
                #1;
                check("rst_rd_en", mem_rd_en, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_wr_en", fifo_wr_en, 0);
                check("rst_wr_data", fifo_wr_data, 0);
                check("rst_done", done, 0);
                break;
            end
            if (ab > 0 && (ncyc - t0) == ab) en = 1'b0;
            if (ab > 0 && (ncyc - t0) >= ab + 10) break;
            if (ab == 0 && n_done > 0) break;
        end
        en = 1'b0;
        @(posedge clk);
        #3;
        job_active = 1'b0;
        fmode      = 0;

        if (rs == 0) begin
            if (ab == 0) begin
                check("done_count", n_done, 1);
                check("reads_left", exp_addr_q.size(), 0);
                check("pushes_left", exp_push_q.size(), 0);
                check("done_after_last_push", done_cyc, last_push + 1);
            end else begin
                check("abort_no_done", n_done, 0);
            end
        end
    endtask

    task automatic check_full_timing(input string pfx);
        check({pfx, "_first_rd"}, first_rd, 1);
        check({pfx, "_last_rd"}, last_rd, 16);
        check({pfx, "_first_push"}, first_push, 3);
        check({pfx, "_last_push"}, last_push, 18);
        check({pfx, "_done_cyc"}, done_cyc, 19);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        num_row   = '0;
        num_col   = '0;
        base_addr = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_en", mem_rd_en, 0);
        check("reset_wr_en", fifo_wr_en, 0);
        check("reset_done", done, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_wr_data", fifo_wr_data, 0);
        #2;
        reset = 1'b0;

        // Full tile, no stalls.
        run_job(4'd15, 4'd15, 8'h10, 0, 0, 0);
        check_full_timing("full");

        // Partial tile: 13 pad rows, then three masked rows.
        run_job(4'd2, 4'd3, 8'h40, 0, 0, 0);
        check("partial_first_push", first_push, 1);
        check("partial_first_rd", first_rd, 14);
        check("partial_n_push", n_push, 16);
        check("partial_done_cyc", done_cyc, 19);

        // Backpressure in cycles 5..9.
        run_job(4'd15, 4'd15, 8'h80, 1, 0, 0);
        check("bp_n_push", n_push, 16);
        check("bp_last_push", last_push, 23);
        check("bp_done_cyc", done_cyc, 24);

        // Address wrap-around.
        run_job(4'd3, 4'd15, 8'hFE, 0, 0, 0);
        check("wrap_first_rd", first_rd, 13);
        check("wrap_n_rd", n_rd, 4);
        check("wrap_done_cyc", done_cyc, 19);

        // Abort in cycle 6, then a fresh job.
        run_job(4'd15, 4'd15, 8'h20, 0, 6, 0);
        repeat (2) @(posedge clk);
        run_job(4'd15, 4'd15, 8'h30, 0, 0, 0);
        check_full_timing("after_abort");

        // Asynchronous reset mid-LOAD, then a restarted job.
        run_job(4'd15, 4'd15, 8'h50, 0, 0, 8);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        run_job(4'd15, 4'd15, 8'h50, 0, 0, 0);
        check_full_timing("after_reset");

        // Randomized jobs with random backpressure.
        for (int j = 0; j < 8; j++) begin
            run_job(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    8'($urandom_range(0, 255)), (j % 2 == 0) ? 2 : 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_mem_fifo_control.md
# weight_mem_fifo_control

Moves one weight tile from weight memory into the weight FIFO that feeds the systolic array. It runs for one tile each time the multiply master raises `weight_mem_fifo_en`, and answers with a one-cycle `weight_mem_fifo_done`. It pads unused rows and masks unused columns, so the FIFO always holds exactly `WIDTH_HEIGHT` full rows in shift-in order.

## Interface
- `WIDTH_HEIGHT`, 16, systolic array dimension (rows = cols)
- `DATA_WIDTH`, `WIDTH_HEIGHT*8`, one row of int8 weights
- `ADDR_WIDTH`, 8, weight memory row-address width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `weight_mem_fifo_en` in 1: job request/hold from the master; level
- `num_row` in `$clog2(WIDTH_HEIGHT)`: valid rows minus one (0 → 1 row)
- `num_col` in `$clog2(WIDTH_HEIGHT)`: valid columns minus one
- `base_addr` in `ADDR_WIDTH`: memory address of tile row 0
- `mem_rd_en` out 1: weight memory read strobe
- `mem_addr` out `ADDR_WIDTH`: read address
- `mem_rd_data` in `DATA_WIDTH`: read data, valid exactly 1 cycle after `mem_rd_en`
- `fifo_wr_en` out 1: push to weight FIFO
- `fifo_wr_data` out `DATA_WIDTH`: pushed row; byte i = column i
- `fifo_full` in 1: FIFO cannot accept a push this cycle
- `weight_mem_fifo_done` out 1: one-cycle pulse, tile fully pushed

## Operation
- States: IDLE, PAD, LOAD, DONE.
- **IDLE**
  - With `weight_mem_fifo_en`=1, latch `num_row`, `num_col` and `base_addr`.
  - `pad_cnt` = `WIDTH_HEIGHT-1-num_row`.
  - Next state is PAD if `pad_cnt`>0, else LOAD.
- **PAD**
  - Push all-zero rows: `fifo_wr_en` = !`fifo_full`; no memory reads.
  - Decrement `pad_cnt` on each push; at 0, go to LOAD.
- **LOAD**
  - Reads descend: addresses `base_addr+num_row` down to `base_addr`, so row 0 is pushed last and lands at the top of the array.
  - Returned rows go into a 2-entry in-order buffer.
  - Push when buffer non-empty and !`fifo_full`.
  - Read issues when reads remain and `buf_count + inflight - push_this_cycle < 2`. This sustains 1 row/cycle with no overflow.
  - Leave LOAD when all `num_row+1` rows are pushed.
- **DONE**
  - `weight_mem_fifo_done`=1 for exactly one cycle, then IDLE unconditionally.
- **Column mask**: on each pushed memory row, bytes with index > `num_col` are forced to 0.
- **Address arithmetic** is modulo `2^ADDR_WIDTH`; wrap-around is legal and not flagged.
- **Abort**: `weight_mem_fifo_en` low in PAD or LOAD sends the block to IDLE next cycle.
  - The buffer is flushed and any in-flight read return is discarded.
  - No done pulse.
  - Rows already pushed stay in the FIFO; flushing it is the master's job.
- **Reset** (any time, mid-job included): state IDLE; buffer, counters and in-flight flag cleared.
- Reset values of all outputs: `mem_rd_en`, `fifo_wr_en` and `weight_mem_fifo_done` = 0; `mem_addr` and `fifo_wr_data` = 0.

## Timing
- Request sampled at edge 0 (full tile, no stalls):
  - `mem_rd_en` is high in cycles 1–16.
  - `fifo_wr_en` is high in cycles 3–18.
  - done pulses in cycle 19.
- With padding, zero pushes start in cycle 1 and memory reads start the cycle after the last pad push.
- `fifo_full`:
  - Stalls pushes with no row lost.
  - Reads stop within the credit rule, so at most 2 rows are ever buffered.
  - Pushes resume the cycle `fifo_full` falls.
- `fifo_full` is sampled combinationally in the same cycle as `fifo_wr_en`.
- done is always one cycle after the final push.

## Structure
- Shared package `tpu_pkg`: state enum, `WIDTH_HEIGHT` default, and a function building the column byte-mask from `num_col`.
- Sub-module `weight_row_buf`: 2-entry in-order buffer with `count` output.
- Remainder is FSM, counters and address generation in this module.

## Test plan
- Full tile: `num_row`=`num_col`=15, `base_addr`=0x10, `fifo_full`=0.
  - Reads at 0x1F→0x10 in cycles 1–16.
  - 16 pushes in cycles 3–18, in address order 0x1F→0x10.
  - Done in cycle 19.
- Partial tile: `num_row`=2, `num_col`=3.
  - 13 zero pushes first, then rows from `base+2`, `base+1`, `base`.
  - Each memory row has only bytes 0–3 nonzero.
- Backpressure: `fifo_full` high for cycles 5–9 on a full tile.
  - No push during the stall.
  - Buffer never exceeds 2 entries.
  - All 16 rows arrive in order.
  - Done is delayed by 5 cycles (cycle 24).
- Address wrap: `base_addr`=0xFE, `num_row`=3.
  - Reads at 0x01, 0x00, 0xFF, 0xFE.
  - 12 pad pushes precede them.
- Abort: drop `weight_mem_fifo_en` in cycle 6 of a full tile.
  - IDLE in cycle 7; no further reads or pushes.
  - No done; a fresh job then completes normally.
- Reset: assert `reset` asynchronously mid-LOAD.
  - All outputs 0 immediately.
  - A restarted job behaves as in the full-tile scenario.
